// File: rtl/pipe_arb_pkg.sv
// Shared constants and helpers for the round-robin pipeline arbiter.
// The stage records depend on N/IDW, so the datapath declares them itself.
package pipe_arb_pkg;

  localparam int LATENCY  = 3;
  localparam int MAX_NREQ = 8;
  localparam int FLIGHT_W = 2;

  function automatic logic [FLIGHT_W-1:0] count_valid3(input logic v0,
                                                       input logic v1,
                                                       input logic v2);
    return {1'b0, v0} + {1'b0, v1} + {1'b0, v2};
  endfunction

endpackage

// File: rtl/pipe_datapath.sv
// Three-stage F = ((A+B) + (C-D)) * D pipeline with valid/ID sideband.
// A single enable freezes every register, so stalls never drop or duplicate work.
module pipe_datapath
  import pipe_arb_pkg::*;
#(
  parameter int N   = 10,
  parameter int IDW = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                in_valid,
  input  logic [IDW-1:0]      in_id,
  input  logic [N-1:0]        in_a,
  input  logic [N-1:0]        in_b,
  input  logic [N-1:0]        in_c,
  input  logic [N-1:0]        in_d,
  output logic                out_valid,
  output logic [N-1:0]        out_f,
  output logic [IDW-1:0]      out_id,
  output logic [FLIGHT_W-1:0] in_flight
);

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
    logic [N-1:0]   d;
    logic [N-1:0]   x1;
    logic [N-1:0]   x2;
  } s1_t;

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
    logic [N-1:0]   d;
    logic [N-1:0]   x3;
  } s2_t;

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
    logic [N-1:0]   f;
  } out_t;

  s1_t  s1_q,  s1_d;
  s2_t  s2_q,  s2_d;
  out_t out_q, out_d;

  // NOTE: every next-state value starts as "hold", so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    s1_d  = s1_q;
    s2_d  = s2_q;
    out_d = out_q;
    if (en) begin
      s1_d.valid = in_valid;
      s1_d.id    = in_id;
      s1_d.d     = in_d;
      s1_d.x1    = in_a + in_b;
      s1_d.x2    = in_c - in_d;

      s2_d.valid = s1_q.valid;
      s2_d.id    = s1_q.id;
      s2_d.d     = s1_q.d;
      s2_d.x3    = s1_q.x1 + s1_q.x2;

      out_d.valid = s2_q.valid;
      // Keep the last result on the bus between pulses instead of garbage.
      if (s2_q.valid) begin
        out_d.id = s2_q.id;
        out_d.f  = s2_q.x3 * s2_q.d;
      end
    end
  end

  // NOTE: the whole stage records are reset, not just the valid bits, so the
  // output bus reads zero after reset; sequential state uses <= only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= '0;
      s2_q  <= '0;
      out_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      out_q <= out_d;
    end
  end

  // A held result stays hidden while frozen and is re-presented on release.
  assign out_valid = out_q.valid & en;
  assign out_f     = out_q.f;
  assign out_id    = out_q.id;
  assign in_flight = count_valid3(s1_q.valid, s2_q.valid, out_q.valid);

endmodule

// File: rtl/pipe_arbiter.sv
// Round-robin arbiter feeding one shared arithmetic pipeline; results come
// back tagged with the requester ID.
module pipe_arbiter
  import pipe_arb_pkg::*;
#(
  parameter  int N    = 10,
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*N-1:0]   req_a,
  input  logic [NREQ*N-1:0]   req_b,
  input  logic [NREQ*N-1:0]   req_c,
  input  logic [NREQ*N-1:0]   req_d,
  input  logic                stall,
  output logic                res_valid,
  output logic [N-1:0]        res_f,
  output logic [IDW-1:0]      res_id,
  output logic [FLIGHT_W-1:0] in_flight
);

  logic [IDW-1:0] last_grant_q, last_grant_d;
  logic [IDW-1:0] grant_idx;
  logic           grant_found;
  logic           transfer;
  logic [N-1:0]   sel_a, sel_b, sel_c, sel_d;

  // Search starts one past the last winner and wraps modulo NREQ.
  always_comb begin
    int             cand;
    logic [IDW-1:0] cand_idx;
    cand        = 0;
    cand_idx    = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand     = (int'(last_grant_q) + k) % NREQ;
      cand_idx = IDW'(cand);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign transfer = grant_found & ~stall;

  always_comb begin
    req_ready = '0;
    if (transfer) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_c = '0;
    sel_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_a = req_a[i*N +: N];
        sel_b = req_b[i*N +: N];
        sel_c = req_c[i*N +: N];
        sel_d = req_d[i*N +: N];
      end
    end
  end

  assign last_grant_d = transfer ? grant_idx : last_grant_q;

  // Reset to NREQ-1 so requester 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= IDW'(NREQ - 1);
    else        last_grant_q <= last_grant_d;
  end

  pipe_datapath #(
    .N   (N),
    .IDW (IDW)
  ) u_datapath (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (~stall),
    .in_valid  (transfer),
    .in_id     (grant_idx),
    .in_a      (sel_a),
    .in_b      (sel_b),
    .in_c      (sel_c),
    .in_d      (sel_d),
    .out_valid (res_valid),
    .out_f     (res_f),
    .out_id    (res_id),
    .in_flight (in_flight)
  );

endmodule
